symb_pll_lock_det: RTL and testbench
====================================

Name: symb_pll_lock_det

Overview:
Lock detector for the symbol clock PLL. Consumes the divided comparator clocks (clk_ref, clk_fbk) produced by the symbol PLL control block, synchronizes both into the system clock domain, and counts rising edges of each over a programmable window. It then declares PLL lock or loss-of-lock with hysteresis. Outputs feed the status/interrupt register block and the demod symbol-timing enable logic.

Parameters:
WIN_W, 16, width of window length and window timer
CNT_W, 12, width of per-window edge counters (saturating)
SYNC_STAGES, 2, synchronizer flops per async input (min 2)

Ports:
clk  input  1  system clock
rs  input  1  reset; synchronous, active-high
clk_ref  input  1  PLL reference clock (async to clk)
clk_fbk  input  1  PLL feedback clock (async to clk)
win_len  input  WIN_W  window length in clk cycles
tol  input  CNT_W  max allowed |ref_count - fbk_count| for a matching window
lock_cnt  input  4  consecutive matching windows needed to declare lock
unlock_cnt  input  4  consecutive failing windows needed to drop lock
lock  output  1  PLL locked status
win_done  output  1  one-cycle pulse: window closed, counts valid
lost_lock  output  1  one-cycle pulse on LOCKED->UNLOCKED
ref_count  output  CNT_W  ref edges in last closed window
fbk_count  output  CNT_W  fbk edges in last closed window
freq_err  output  CNT_W+1  signed ref_count - fbk_count, last window

Behaviour:
- Reset (rs=1 at posedge clk): all outputs 0, synchronizers/edge regs 0, counters and timer 0, state UNLOCKED, good/bad counters 0. Reset mid-window discards the window; no win_done.
- Input path: SYNC_STAGES flop chain per input, then one edge register; rising-edge pulse = sync & !prev. Edge pulses lag the input by SYNC_STAGES+1 cycles. Input highs/lows shorter than 2 clk periods are not guaranteed counted (documented limitation; max countable rate clk/4).
- Edge counters increment on each pulse; saturate at all-ones, no wrap.
- Window timer: win_len latched into win_len_q at every window start (after reset and after each close). Timer counts 0..win_len_q-1; terminal cycle = win_len_q-1. Edge in terminal cycle counts in closing window. On terminal cycle: counters cleared to 0 next cycle; ref_count/fbk_count/freq_err registered; win_done=1 the following cycle.
- win_len < 2: detector idle: timer and counters held 0, no win_done, state forced UNLOCKED, good/bad cleared; lock=0 (no lost_lock pulse). Resumes with fresh window when win_len >= 2.
- Window evaluation (in cycle win_done asserts, using registered counts and current tol/lock_cnt/unlock_cnt): match = |freq_err| <= tol AND ref_count != 0 AND fbk_count != 0 AND neither count saturated.
- FSM, two states:
  UNLOCKED: match -> good++; if good+1 >= max(lock_cnt,1) -> LOCKED, good=0. No match -> good=0.
  LOCKED: no match -> bad++; if bad+1 >= max(unlock_cnt,1) -> UNLOCKED, bad=0, lost_lock pulse. Match -> bad=0.
- lock register updates in the same cycle as win_done (registered, visible next cycle). lost_lock coincides with lock falling.
- good/bad counters 4-bit, saturating.

Decomposition:
- Shared defines file: state encodings (LD_UNLOCKED=0, LD_LOCKED=1) and default field widths, alongside existing symb PLL defines.
- One sub-module natural: lock_det_edge_sync (SYNC_STAGES synchronizer + rising-edge pulse), instantiated twice.

Test Plan:
- clk 100 MHz, clk_ref=clk_fbk=1 MHz same phase, win_len=1000, tol=1, lock_cnt=3 -> ref_count=fbk_count=10, freq_err=0, lock rises with 3rd win_done (~30 us), lost_lock never pulses.
- Locked as above, then clk_fbk -> 1.1 MHz, unlock_cnt=2 -> freq_err=-1 or -2 per window; with tol=0, lock drops and lost_lock pulses once on 2nd failing win_done.
- clk_fbk stuck low, clk_ref 1 MHz -> fbk_count=0, no match, lock stays 0 indefinitely.
- CNT_W=4, clk_ref=clk_fbk=5 MHz, win_len=1000 -> counts saturate at 15, match=0, lock never asserts.
- rs pulsed mid-window while LOCKED -> next cycle lock=0, all outputs 0, no win_done until full new window.
- win_len=1 while LOCKED -> lock=0, no lost_lock, no win_done; restore win_len=1000 -> first win_done 1000 cycles +1 later.

Source files
------------

// File: rtl/symb_pll_lock_det_pkg.sv
// Shared definitions for the symbol PLL lock detector: state encoding, default widths
// and the hysteresis counter helpers.
package symb_pll_lock_det_pkg;

    localparam int unsigned LD_WIN_W_DEF       = 16;
    localparam int unsigned LD_CNT_W_DEF       = 12;
    localparam int unsigned LD_SYNC_STAGES_DEF = 2;
    localparam int unsigned LD_HYST_W          = 4;

    typedef enum logic {
        LdUnlocked = 1'b0,
        LdLocked   = 1'b1
    } ld_state_e;

    // A programmed threshold of zero behaves as one window.
    function automatic logic hyst_reached(input logic [LD_HYST_W-1:0] cnt,
                                          input logic [LD_HYST_W-1:0] n);
        logic [LD_HYST_W:0] thr;
        thr = (n == '0) ? (LD_HYST_W+1)'(1) : {1'b0, n};
        return ({1'b0, cnt} + (LD_HYST_W+1)'(1)) >= thr;
    endfunction

    function automatic logic [LD_HYST_W-1:0] hyst_inc(input logic [LD_HYST_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + LD_HYST_W'(1);
    endfunction

endpackage

// File: rtl/symb_pll_lock_det_edge_sync.sv
// Brings one asynchronous comparator clock into the system domain and emits a
// single-cycle pulse per rising edge.
module symb_pll_lock_det_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rs,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rs) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/symb_pll_lock_det.sv
// Symbol PLL lock detector: counts ref/fbk edges over a programmable window and
// declares lock or loss-of-lock with consecutive-window hysteresis.
module symb_pll_lock_det
    import symb_pll_lock_det_pkg::*;
#(
    parameter int unsigned WIN_W       = LD_WIN_W_DEF,
    parameter int unsigned CNT_W       = LD_CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = LD_SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rs,
    input  logic                 clk_ref,
    input  logic                 clk_fbk,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [CNT_W-1:0]     tol,
    input  logic [3:0]           lock_cnt,
    input  logic [3:0]           unlock_cnt,
    output logic                 lock,
    output logic                 win_done,
    output logic                 lost_lock,
    output logic [CNT_W-1:0]     ref_count,
    output logic [CNT_W-1:0]     fbk_count,
    output logic [CNT_W:0]       freq_err
);

    logic ref_pulse, fbk_pulse;

    symb_pll_lock_det_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ref_sync (
        .clk     (clk),
        .rs      (rs),
        .async_i (clk_ref),
        .pulse_o (ref_pulse)
    );

    symb_pll_lock_det_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_fbk_sync (
        .clk     (clk),
        .rs      (rs),
        .async_i (clk_fbk),
        .pulse_o (fbk_pulse)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    logic [WIN_W-1:0] timer_q, timer_d, win_len_q, win_len_d, len_eff;
    logic [CNT_W-1:0] ref_acc_q, ref_acc_d, fbk_acc_q, fbk_acc_d;
    logic [CNT_W-1:0] ref_fin, fbk_fin;
    logic [CNT_W-1:0] ref_count_q, ref_count_d, fbk_count_q, fbk_count_d;
    logic [CNT_W:0]   freq_err_q, freq_err_d, abs_err;
    logic             win_done_q, win_done_d;
    logic             idle, terminal, match;

    assign idle = (win_len < WIN_W'(2));
    // Timer value 0 is the first cycle of a window, where the live length is captured.
    assign len_eff  = (timer_q == '0) ? win_len : win_len_q;
    assign terminal = (timer_q == len_eff - WIN_W'(1));
    assign ref_fin  = sat_inc(ref_acc_q, ref_pulse);
    assign fbk_fin  = sat_inc(fbk_acc_q, fbk_pulse);

    always_comb begin
        timer_d     = timer_q;
        win_len_d   = win_len_q;
        ref_acc_d   = ref_acc_q;
        fbk_acc_d   = fbk_acc_q;
        ref_count_d = ref_count_q;
        fbk_count_d = fbk_count_q;
        freq_err_d  = freq_err_q;
        win_done_d  = 1'b0;
        if (idle) begin
            timer_d   = '0;
            ref_acc_d = '0;
            fbk_acc_d = '0;
        end else begin
            if (timer_q == '0) begin
                win_len_d = win_len;
            end
            if (terminal) begin
                timer_d     = '0;
                ref_acc_d   = '0;
                fbk_acc_d   = '0;
                ref_count_d = ref_fin;
                fbk_count_d = fbk_fin;
                freq_err_d  = {1'b0, ref_fin} - {1'b0, fbk_fin};
                win_done_d  = 1'b1;
            end else begin
                timer_d   = timer_q + WIN_W'(1);
                ref_acc_d = ref_fin;
                fbk_acc_d = fbk_fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            timer_q     <= '0;
            win_len_q   <= '0;
            ref_acc_q   <= '0;
            fbk_acc_q   <= '0;
            ref_count_q <= '0;
            fbk_count_q <= '0;
            freq_err_q  <= '0;
            win_done_q  <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            win_len_q   <= win_len_d;
            ref_acc_q   <= ref_acc_d;
            fbk_acc_q   <= fbk_acc_d;
            ref_count_q <= ref_count_d;
            fbk_count_q <= fbk_count_d;
            freq_err_q  <= freq_err_d;
            win_done_q  <= win_done_d;
        end
    end

    assign abs_err = freq_err_q[CNT_W] ? -freq_err_q : freq_err_q;
    assign match   = (abs_err <= {1'b0, tol}) &&
                     (ref_count_q != '0) && (fbk_count_q != '0) &&
                     (ref_count_q != '1) && (fbk_count_q != '1);

    ld_state_e            state_q;
    logic [LD_HYST_W-1:0] good_q, bad_q;
    logic                 lock_q, lost_lock_q;

    always_ff @(posedge clk) begin
        if (rs || idle) begin
            state_q     <= LdUnlocked;
            good_q      <= '0;
            bad_q       <= '0;
            lock_q      <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            lost_lock_q <= 1'b0;
            if (win_done_q) begin
                unique case (state_q)
                    LdUnlocked: begin
                        if (!match) begin
                            good_q <= '0;
                        end else if (hyst_reached(good_q, lock_cnt)) begin
                            state_q <= LdLocked;
                            lock_q  <= 1'b1;
                            good_q  <= '0;
                        end else begin
                            good_q <= hyst_inc(good_q);
                        end
                    end
                    LdLocked: begin
                        if (match) begin
                            bad_q <= '0;
                        end else if (hyst_reached(bad_q, unlock_cnt)) begin
                            state_q     <= LdUnlocked;
                            lock_q      <= 1'b0;
                            bad_q       <= '0;
                            lost_lock_q <= 1'b1;
                        end else begin
                            bad_q <= hyst_inc(bad_q);
                        end
                    end
                    default: state_q <= LdUnlocked;
                endcase
            end
        end
    end

    assign lock      = lock_q;
    assign lost_lock = lost_lock_q;
    assign win_done  = win_done_q;
    assign ref_count = ref_count_q;
    assign fbk_count = fbk_count_q;
    assign freq_err  = freq_err_q;

endmodule

// File: tb/tb_symb_pll_lock_det.sv
// Directed bench for the symbol PLL lock detector: per-window edge bursts from a table
// plus reset, idle and window-timing sequences.
module tb_symb_pll_lock_det;

    localparam int unsigned CW = 6;
    localparam int unsigned WL = 400;

    logic          clk = 1'b0;
    logic          rs;
    logic          clk_ref, clk_fbk;
    logic [15:0]   win_len;
    logic [CW-1:0] tol;
    logic [3:0]    lock_cnt, unlock_cnt;
    logic          lock, win_done, lost_lock;
    logic [CW-1:0] ref_count, fbk_count;
    logic [CW:0]   freq_err;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int nr; int nf; int tol; int lc; int uc;
        int rc; int fc; int err; int lk; int lost;
    } vec_t;

    vec_t vecs[16];

    symb_pll_lock_det #(
        .WIN_W       (16),
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rs         (rs),
        .clk_ref    (clk_ref),
        .clk_fbk    (clk_fbk),
        .win_len    (win_len),
        .tol        (tol),
        .lock_cnt   (lock_cnt),
        .unlock_cnt (unlock_cnt),
        .lock       (lock),
        .win_done   (win_done),
        .lost_lock  (lost_lock),
        .ref_count  (ref_count),
        .fbk_count  (fbk_count),
        .freq_err   (freq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (win_done) break;
        end
        if (!win_done) begin
            n_chk++;
            n_err++;
            $display("FAIL win_done_timeout: none within %0d cycles", bound);
        end
    endtask

    // Rising edges every 4 cycles, 2 high / 2 low, starting at the current negedge.
    task automatic drive_edges(input int nr, input int nf, input int len);
        for (int i = 0; i < len; i++) begin
            clk_ref = ((i / 4) < nr) && ((i % 4) < 2);
            clk_fbk = ((i / 4) < nf) && ((i % 4) < 2);
            @(negedge clk);
        end
        clk_ref = 1'b0;
        clk_fbk = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " lock"}, int'(lock), 0);
        chk({tag, " win_done"}, int'(win_done), 0);
        chk({tag, " lost_lock"}, int'(lost_lock), 0);
        chk({tag, " ref_count"}, int'(ref_count), 0);
        chk({tag, " fbk_count"}, int'(fbk_count), 0);
        chk({tag, " freq_err"}, int'(freq_err), 0);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int n;
        tol        = CW'(v.tol);
        lock_cnt   = 4'(v.lc);
        unlock_cnt = 4'(v.uc);
        drive_edges(v.nr, v.nf, 288);
        wait_done(1000, n);
        chk($sformatf("v%0d ref_count", idx), int'(ref_count), v.rc);
        chk($sformatf("v%0d fbk_count", idx), int'(fbk_count), v.fc);
        chk($sformatf("v%0d freq_err", idx), int'($signed(freq_err)), v.err);
        @(negedge clk);
        chk($sformatf("v%0d lock", idx), int'(lock), v.lk);
        chk($sformatf("v%0d lost_lock", idx), int'(lost_lock), v.lost);
    endtask

    initial begin
        int n;
        int bad;
        rs = 1'b1; clk_ref = 1'b0; clk_fbk = 1'b0;
        win_len = 16'(WL); tol = '0; lock_cnt = 4'd3; unlock_cnt = 4'd2;

        //            nr  nf tol lc uc  rc  fc  err lk lost
        vecs[0]  = '{10, 10,  1, 3, 2, 10, 10,   0, 0, 0};
        vecs[1]  = '{10, 11,  1, 3, 2, 10, 11,  -1, 0, 0};
        vecs[2]  = '{10,  9,  1, 3, 2, 10,  9,   1, 1, 0};
        vecs[3]  = '{10, 12,  1, 3, 2, 10, 12,  -2, 1, 0};
        vecs[4]  = '{10, 10,  1, 3, 2, 10, 10,   0, 1, 0};
        vecs[5]  = '{10, 13,  1, 3, 2, 10, 13,  -3, 1, 0};
        vecs[6]  = '{ 0,  0,  1, 3, 2,  0,  0,   0, 0, 1};
        vecs[7]  = '{ 5,  0, 63, 3, 2,  5,  0,   5, 0, 0};
        vecs[8]  = '{ 0,  5, 63, 3, 2,  0,  5,  -5, 0, 0};
        vecs[9]  = '{70, 70, 63, 1, 2, 63, 63,   0, 0, 0};
        vecs[10] = '{63, 62,  1, 1, 2, 63, 62,   1, 0, 0};
        vecs[11] = '{62, 62,  0, 0, 2, 62, 62,   0, 1, 0};
        vecs[12] = '{20, 25,  5, 0, 0, 20, 25,  -5, 1, 0};
        vecs[13] = '{20, 26,  5, 0, 0, 20, 26,  -6, 0, 1};
        vecs[14] = '{30,  1, 63, 2, 0, 30,  1,  29, 0, 0};
        vecs[15] = '{ 1, 30, 63, 2, 0,  1, 30, -29, 1, 0};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rs = 1'b0;

        wait_done(1000, n);
        chk("first_window_len", n, WL);
        chk("first_window ref_count", int'(ref_count), 0);

        for (int i = 0; i < 16; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Reset in the middle of a locked window.
        drive_edges(10, 10, 40);
        rs = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rs = 1'b0;
        wait_done(1000, n);
        chk("post_reset_window_len", n, WL);
        chk("post_reset ref_count", int'(ref_count), 0);
        @(negedge clk);
        chk("post_reset lock", int'(lock), 0);

        apply_vec(16, '{10, 10, 0, 1, 1, 10, 10, 0, 1, 0});

        // Short window length idles the detector without a loss-of-lock pulse.
        win_len = 16'd1;
        @(negedge clk);
        chk("idle lock", int'(lock), 0);
        chk("idle lost_lock", int'(lost_lock), 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (win_done || lost_lock || lock) bad++;
        end
        chk("idle_quiet_cycles", bad, 0);
        win_len = 16'(WL);
        wait_done(1000, n);
        chk("resume_window_len", n, WL);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
